// File: rtl/ft245_async_bridge.sv
// Bridge between the FT2232H 245-style asynchronous FIFO pins and internal RX/TX FIFOs.
// Optional macro FT_FLAG_SYNC_EN: 2-flop synchronisers on iRxF_n/iTxE_n, high phases >= 3.
module ft245_async_bridge #(
    parameter int unsigned RD_LOW_CYC  = 2,
    parameter int unsigned RD_HIGH_CYC = 2,
    parameter int unsigned WR_LOW_CYC  = 2,
    parameter int unsigned WR_HIGH_CYC = 2,
    parameter int unsigned BURST_MAX   = 4,
    parameter int unsigned ARB_RR      = 1,
    parameter int unsigned SIWU_IDLE   = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    output logic       oTxRdEn,
    input  logic       iTxRdEmpty,
    input  logic [7:0] iTxData,
    output logic       oRxWrEn,
    input  logic       iRxWrFull,
    output logic [7:0] oRxData,
    inout  wire  [7:0] ioFifoData,
    input  logic       iRxF_n,
    input  logic       iTxE_n,
    output logic       oRx_n,
    output logic       oTx_n,
    output logic       oSiwu
);
    logic rf_n, te_n;

`ifdef FT_FLAG_SYNC_EN
    localparam int unsigned RdHighEff = (RD_HIGH_CYC > 3) ? RD_HIGH_CYC : 3;
    localparam int unsigned WrHighEff = (WR_HIGH_CYC > 3) ? WR_HIGH_CYC : 3;
    logic [1:0] rxf_sync_q, txe_sync_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rxf_sync_q <= 2'b11;
            txe_sync_q <= 2'b11;
        end else begin
            rxf_sync_q <= {rxf_sync_q[0], iRxF_n};
            txe_sync_q <= {txe_sync_q[0], iTxE_n};
        end
    end
    assign rf_n = rxf_sync_q[1];
    assign te_n = txe_sync_q[1];
`else
    localparam int unsigned RdHighEff = RD_HIGH_CYC;
    localparam int unsigned WrHighEff = WR_HIGH_CYC;
    assign rf_n = iRxF_n;
    assign te_n = iTxE_n;
`endif

    localparam int unsigned MaxRd  = (RD_LOW_CYC > RdHighEff) ? RD_LOW_CYC : RdHighEff;
    localparam int unsigned MaxWr  = (WR_LOW_CYC > WrHighEff) ? WR_LOW_CYC : WrHighEff;
    localparam int unsigned CycMax = (MaxRd > MaxWr) ? MaxRd : MaxWr;
    localparam int unsigned CycW   = $clog2(CycMax + 1);
    localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
    localparam int unsigned SiwuW  = (SIWU_IDLE > 0) ? $clog2(SIWU_IDLE + 1) : 1;
    localparam bit          SiwuEn = (SIWU_IDLE != 0);

    typedef enum logic [3:0] {
        StIdle, StRdLow, StRdHigh, StTxFetch, StTxSetup, StWrLow, StWrHold, StWrHigh, StSiwu
    } state_e;

    state_e            state_q, state_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [SiwuW-1:0]  idle_q, idle_d;
    logic              last_tx_q, last_tx_d;
    logic              armed_q, armed_d;
    logic [7:0]        rx_data_q, rx_data_d, tx_data_q, tx_data_d;
    logic              rx_wr_en_q, rx_wr_en_d;
    logic              rx_n_q, tx_n_q, tx_rd_en_q, oe_q, siwu_n_q;

    logic rx_rdy, tx_rdy, burst_more, siwu_fire;
    assign rx_rdy     = !rf_n && !iRxWrFull;
    assign tx_rdy     = !te_n && !iTxRdEmpty;
    assign burst_more = burst_q < BurstW'(BURST_MAX);
    assign siwu_fire  = SiwuEn && armed_q && (idle_q == SiwuW'(SIWU_IDLE - 1));

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        burst_d    = burst_q;
        idle_d     = idle_q;
        last_tx_d  = last_tx_q;
        armed_d    = armed_q;
        rx_data_d  = rx_data_q;
        tx_data_d  = tx_data_q;
        rx_wr_en_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                // last_tx_q resets to 1 so RX wins the first contended arbitration
                if (rx_rdy && (!tx_rdy || (ARB_RR == 0) || last_tx_q)) begin
                    state_d   = StRdLow;
                    last_tx_d = 1'b0;
                    if (!armed_q) idle_d = '0;
                end else if (tx_rdy) begin
                    state_d   = StTxFetch;
                    last_tx_d = 1'b1;
                end else if (siwu_fire) begin
                    state_d = StSiwu;
                    armed_d = 1'b0;
                    idle_d  = '0;
                end else if (armed_q) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StRdLow: begin
                if (cyc_q == CycW'(RD_LOW_CYC - 1)) begin
                    rx_data_d  = ioFifoData;
                    rx_wr_en_d = 1'b1;
                    burst_d    = burst_q + 1'b1;
                    cyc_d      = '0;
                    state_d    = StRdHigh;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StRdHigh: begin
                if (cyc_q == CycW'(RdHighEff - 1)) begin
                    cyc_d   = '0;
                    state_d = (rx_rdy && burst_more) ? StRdLow : StIdle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StTxFetch: state_d = StTxSetup;
            StTxSetup: begin
                tx_data_d = iTxData;
                cyc_d     = '0;
                state_d   = StWrLow;
            end
            StWrLow: begin
                if (cyc_q == CycW'(WR_LOW_CYC - 1)) begin
                    burst_d = burst_q + 1'b1;
                    armed_d = SiwuEn;
                    idle_d  = '0;
                    cyc_d   = '0;
                    state_d = StWrHold;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StWrHold: state_d = StWrHigh;
            StWrHigh: begin
                if (cyc_q == CycW'(WrHighEff - 1)) begin
                    cyc_d   = '0;
                    state_d = (tx_rdy && burst_more) ? StTxFetch : StIdle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StSiwu: begin
                if (cyc_q == CycW'(1)) begin
                    cyc_d   = '0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) burst_d = '0;
    end

    // Pin-facing strobes are registered from the next state so they are glitch-free
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= StIdle;
            cyc_q      <= '0;
            burst_q    <= '0;
            idle_q     <= '0;
            last_tx_q  <= 1'b1;
            armed_q    <= 1'b0;
            rx_data_q  <= 8'h00;
            tx_data_q  <= 8'h00;
            rx_wr_en_q <= 1'b0;
            rx_n_q     <= 1'b1;
            tx_n_q     <= 1'b1;
            tx_rd_en_q <= 1'b0;
            oe_q       <= 1'b0;
            siwu_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            last_tx_q  <= last_tx_d;
            armed_q    <= armed_d;
            rx_data_q  <= rx_data_d;
            tx_data_q  <= tx_data_d;
            rx_wr_en_q <= rx_wr_en_d;
            rx_n_q     <= (state_d != StRdLow);
            tx_n_q     <= (state_d != StWrLow);
            tx_rd_en_q <= (state_d == StTxFetch);
            oe_q       <= (state_d inside {StTxSetup, StWrLow, StWrHold});
            siwu_n_q   <= (state_d != StSiwu);
        end
    end

    assign ioFifoData = oe_q ? tx_data_q : 8'hzz;
    assign oRxData    = rx_data_q;
    assign oRxWrEn    = rx_wr_en_q;
    assign oTxRdEn    = tx_rd_en_q;
    assign oRx_n      = rx_n_q;
    assign oTx_n      = tx_n_q;
    assign oSiwu      = siwu_n_q;
endmodule

// File: tb/tb_ft245_async_bridge.sv
// Self-checking bench for ft245_async_bridge: FTDI/FIFO models plus scoreboard queues.
module tb_ft245_async_bridge;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_rd_en, rx_wr_en, rx_n, tx_n, siwu_n;
    logic       tx_empty = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       rx_full = 1'b0;
    logic [7:0] rx_data;
    logic       rxf_n = 1'b1;
    logic       txe_n = 1'b1;
    wire  [7:0] bus;
    logic [7:0] host_byte = 8'h00;
    logic       probe_en = 1'b0;
    logic       rx_n_prev = 1'b1;

    logic [7:0] host_q[$];
    logic [7:0] txf_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Host side drives the bus while RD# is low; probe drives a known value to detect contention
    assign bus = probe_en ? 8'h3C : (!rx_n ? host_byte : 8'hzz);

    ft245_async_bridge dut (
        .iClk(clk), .iRst_n(rst_n),
        .oTxRdEn(tx_rd_en), .iTxRdEmpty(tx_empty), .iTxData(tx_data),
        .oRxWrEn(rx_wr_en), .iRxWrFull(rx_full), .oRxData(rx_data),
        .ioFifoData(bus), .iRxF_n(rxf_n), .iTxE_n(txe_n),
        .oRx_n(rx_n), .oTx_n(tx_n), .oSiwu(siwu_n)
    );

    // FTDI host model: byte is consumed when RD# rises
    always @(negedge clk) begin
        int n;
        n = host_q.size();
        if (!rx_n_prev && rx_n && n > 0) begin
            void'(host_q.pop_front());
            n = n - 1;
        end
        rx_n_prev <= rx_n;
        rxf_n     <= (n == 0);
        if (n > 0) host_byte <= host_q[0];
    end

    // TX FIFO model: data valid the cycle after the read strobe
    always @(negedge clk) begin
        int n;
        n = txf_q.size();
        if (tx_rd_en && n > 0) begin
            tx_data <= txf_q.pop_front();
            n = n - 1;
        end
        tx_empty <= (n == 0);
    end

    // Arbitration instances: both sides permanently ready once arb_go is set
    logic       arb_go = 1'b0;
    logic       a1_tx_rd_en, a1_rx_wr_en, a1_rx_n, a1_tx_n, a1_siwu_n;
    logic       a2_tx_rd_en, a2_rx_wr_en, a2_rx_n, a2_tx_n, a2_siwu_n;
    logic [7:0] a1_rx_data, a2_rx_data;
    wire  [7:0] a1_bus, a2_bus;
    assign a1_bus = !a1_rx_n ? 8'h11 : 8'hzz;
    assign a2_bus = !a2_rx_n ? 8'h11 : 8'hzz;

    ft245_async_bridge #(.BURST_MAX(1), .ARB_RR(1), .SIWU_IDLE(0)) dut_rr (
        .iClk(clk), .iRst_n(rst_n),
        .oTxRdEn(a1_tx_rd_en), .iTxRdEmpty(!arb_go), .iTxData(8'h55),
        .oRxWrEn(a1_rx_wr_en), .iRxWrFull(1'b0), .oRxData(a1_rx_data),
        .ioFifoData(a1_bus), .iRxF_n(!arb_go), .iTxE_n(!arb_go),
        .oRx_n(a1_rx_n), .oTx_n(a1_tx_n), .oSiwu(a1_siwu_n)
    );

    ft245_async_bridge #(.BURST_MAX(1), .ARB_RR(0), .SIWU_IDLE(0)) dut_pri (
        .iClk(clk), .iRst_n(rst_n),
        .oTxRdEn(a2_tx_rd_en), .iTxRdEmpty(!arb_go), .iTxData(8'h55),
        .oRxWrEn(a2_rx_wr_en), .iRxWrFull(1'b0), .oRxData(a2_rx_data),
        .ioFifoData(a2_bus), .iRxF_n(!arb_go), .iTxE_n(!arb_go),
        .oRx_n(a2_rx_n), .oTx_n(a2_tx_n), .oSiwu(a2_siwu_n)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rx_n, tx_n, siwu_n, tx_rd_en, rx_wr_en} !== 5'b11100)
            $display("FAIL reset_strobes got %b want 11100",
                     {rx_n, tx_n, siwu_n, tx_rd_en, rx_wr_en});
        else n_pass++;
        n_total++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data);
        else n_pass++;
        probe_en = 1'b1;
        #1;
        n_total++;
        if (bus !== 8'h3C) $display("FAIL reset_bus_z got %h want 3c (probe only)", bus);
        else n_pass++;
        probe_en = 1'b0;
    endtask

    task automatic test_rx_single();
        int low_cyc = 0, pulses = 0, fall_t = -1, wr_t = -1;
        logic [7:0] e;
        host_q.push_back(8'hA5);
        exp_rx.push_back(8'hA5);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!rx_n) begin
                low_cyc++;
                if (fall_t < 0) fall_t = t;
            end
            if (rx_wr_en) begin
                pulses++;
                wr_t = t;
                n_total++;
                if (exp_rx.size() == 0) $display("FAIL rx_single_extra got %h want none", rx_data);
                else begin
                    e = exp_rx.pop_front();
                    if (rx_data !== e) $display("FAIL rx_single_data got %h want %h", rx_data, e);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (low_cyc != 2) $display("FAIL rx_single_low_cycles got %0d want 2", low_cyc);
        else n_pass++;
        n_total++;
        if (pulses != 1) $display("FAIL rx_single_pulses got %0d want 1", pulses);
        else n_pass++;
        n_total++;
        if (wr_t - fall_t != 2) $display("FAIL rx_single_latency got %0d want 2", wr_t - fall_t);
        else n_pass++;
    endtask

    task automatic test_rx_burst();
        int falls[$];
        logic prev = 1'b1;
        logic [7:0] e;
        for (int b = 1; b <= 6; b++) begin
            host_q.push_back(8'(b));
            exp_rx.push_back(8'(b));
        end
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (prev && !rx_n) falls.push_back(t);
            prev = rx_n;
            if (rx_wr_en) begin
                n_total++;
                if (exp_rx.size() == 0) $display("FAIL rx_burst_extra got %h want none", rx_data);
                else begin
                    e = exp_rx.pop_front();
                    if (rx_data !== e) $display("FAIL rx_burst_data got %h want %h", rx_data, e);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (falls.size() != 6 || exp_rx.size() != 0)
            $display("FAIL rx_burst_count got %0d reads want 6", falls.size());
        else n_pass++;
        for (int i = 1; i < falls.size(); i++) begin
            n_total++;
            if (falls[i] - falls[i-1] != ((i == 4) ? 5 : 4))
                $display("FAIL rx_burst_gap%0d got %0d want %0d", i, falls[i] - falls[i-1],
                         (i == 4) ? 5 : 4);
            else n_pass++;
        end
    endtask

    task automatic test_rx_full();
        int lows = 0, pulses = 0;
        logic [7:0] e;
        rx_full = 1'b1;
        host_q.push_back(8'h5E);
        exp_rx.push_back(8'h5E);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (!rx_n) lows++;
        end
        n_total++;
        if (lows != 0) $display("FAIL rx_full_stall got %0d strobe cycles want 0", lows);
        else n_pass++;
        rx_full = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rx_wr_en) begin
                pulses++;
                n_total++;
                if (exp_rx.size() == 0) $display("FAIL rx_full_extra got %h want none", rx_data);
                else begin
                    e = exp_rx.pop_front();
                    if (rx_data !== e) $display("FAIL rx_full_data got %h want %h", rx_data, e);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (pulses != 1) $display("FAIL rx_full_resume got %0d writes want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_tx_flow();
        int writes = 0, bad = 0, rd_t = -1, low_t = -1;
        logic prev = 1'b1;
        logic [7:0] e;
        txf_q.push_back(8'h81); txf_q.push_back(8'h42); txf_q.push_back(8'h24);
        exp_tx.push_back(8'h81); exp_tx.push_back(8'h42); exp_tx.push_back(8'h24);
        txe_n = 1'b0;
        for (int t = 0; t < 100 && writes < 2; t++) begin
            @(negedge clk);
            if (!prev && tx_n) begin
                writes++;
                e = exp_tx.pop_front();
                n_total++;
                if (bus !== e) $display("FAIL tx_flow_data%0d got %h want %h", writes, bus, e);
                else n_pass++;
                if (writes == 2) txe_n = 1'b1;
            end
            prev = tx_n;
        end
        n_total++;
        if (writes != 2) $display("FAIL tx_flow_timeout got %0d writes want 2", writes);
        else n_pass++;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (!tx_n || tx_rd_en) bad++;
            if (t == 3) begin
                probe_en = 1'b1;
                #1;
                n_total++;
                if (bus !== 8'h3C) $display("FAIL tx_flow_bus_z got %h want 3c (probe only)", bus);
                else n_pass++;
                probe_en = 1'b0;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL tx_flow_stalled got %0d active cycles want 0", bad);
        else n_pass++;
        txe_n = 1'b0;
        prev = 1'b1;
        for (int t = 1; t <= 20 && exp_tx.size() > 0; t++) begin
            @(negedge clk);
            if (tx_rd_en && rd_t < 0) rd_t = t;
            if (!tx_n && low_t < 0) low_t = t;
            if (!prev && tx_n) begin
                e = exp_tx.pop_front();
                n_total++;
                if (bus !== e) $display("FAIL tx_flow_data3 got %h want %h", bus, e);
                else n_pass++;
            end
            prev = tx_n;
        end
        n_total++;
        if (rd_t != 1 || low_t != 3)
            $display("FAIL tx_flow_latency got rd=%0d low=%0d want rd=1 low=3", rd_t, low_t);
        else n_pass++;
    endtask

    task automatic test_siwu();
        int h = -1, first_low = -1, low_cyc = 0, pulses = 0;
        logic prev = 1'b1, sprev = 1'b1;
        logic [7:0] e;
        txf_q.push_back(8'h99);
        exp_tx.push_back(8'h99);
        for (int t = 0; t < 40 && h < 0; t++) begin
            @(negedge clk);
            if (!prev && tx_n) begin
                h = t;
                e = exp_tx.pop_front();
                n_total++;
                if (bus !== e) $display("FAIL siwu_write_data got %h want %h", bus, e);
                else n_pass++;
            end
            prev = tx_n;
        end
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!siwu_n) begin
                low_cyc++;
                if (first_low < 0) first_low = k;
            end
            if (sprev && !siwu_n) pulses++;
            sprev = siwu_n;
        end
        n_total++;
        if (first_low != 19) $display("FAIL siwu_delay got %0d want 19", first_low);
        else n_pass++;
        n_total++;
        if (low_cyc != 2 || pulses != 1)
            $display("FAIL siwu_pulse got %0d cycles/%0d pulses want 2/1", low_cyc, pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int seen = 0;
        logic prev = 1'b1;
        logic [7:0] e;
        txf_q.push_back(8'hC3);
        for (int t = 0; t < 30 && tx_n; t++) @(negedge clk);
        n_total++;
        if (tx_n !== 1'b0) $display("FAIL rst_mid_reach_wr_low got %b want 0", tx_n);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({tx_n, tx_rd_en, rx_n, siwu_n} !== 4'b1011)
            $display("FAIL rst_mid_async got %b want 1011", {tx_n, tx_rd_en, rx_n, siwu_n});
        else n_pass++;
        probe_en = 1'b1;
        #1;
        n_total++;
        if (bus !== 8'h3C) $display("FAIL rst_mid_bus_z got %h want 3c (probe only)", bus);
        else n_pass++;
        probe_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txf_q.push_back(8'h77);
        exp_tx.push_back(8'h77);
        for (int t = 0; t < 40 && exp_tx.size() > 0; t++) begin
            @(negedge clk);
            if (!prev && tx_n) begin
                seen++;
                e = exp_tx.pop_front();
                n_total++;
                if (bus !== e) $display("FAIL rst_mid_after_data got %h want %h", bus, e);
                else n_pass++;
            end
            prev = tx_n;
        end
        n_total++;
        if (seen != 1) $display("FAIL rst_mid_after_timeout got %0d writes want 1", seen);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        logic [7:0] exp_a1[$];
        logic [7:0] exp_a2[$];
        logic p1r = 1'b1, p1t = 1'b1, p2r = 1'b1;
        int a2_tx = 0, a1_siwu = 0, bad_data = 0;
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            exp_a1.push_back("R");
            exp_a1.push_back("T");
        end
        for (int i = 0; i < 4; i++) exp_a2.push_back("R");
        arb_go = 1'b1;
        for (int t = 0; t < 200 && (exp_a1.size() > 0 || exp_a2.size() > 0); t++) begin
            @(negedge clk);
            if (p1r && !a1_rx_n && exp_a1.size() > 0) begin
                e = exp_a1.pop_front();
                n_total++;
                if (e !== "R") $display("FAIL arb_rr_order got R want %c", e);
                else n_pass++;
            end
            if (p1t && !a1_tx_n && exp_a1.size() > 0) begin
                e = exp_a1.pop_front();
                n_total++;
                if (e !== "T") $display("FAIL arb_rr_order got T want %c", e);
                else n_pass++;
            end
            if (!p1t && a1_tx_n && a1_bus !== 8'h55) bad_data++;
            if (p2r && !a2_rx_n && exp_a2.size() > 0) begin
                e = exp_a2.pop_front();
                n_total++;
                if (e !== "R") $display("FAIL arb_pri_order got R want %c", e);
                else n_pass++;
            end
            if (a1_rx_wr_en && a1_rx_data !== 8'h11) bad_data++;
            if (a2_rx_wr_en && a2_rx_data !== 8'h11) bad_data++;
            if (a2_tx_rd_en || !a2_tx_n || !a2_siwu_n) a2_tx++;
            if (!a1_siwu_n || a1_tx_rd_en === 1'bx) a1_siwu++;
            p1r = a1_rx_n;
            p1t = a1_tx_n;
            p2r = a2_rx_n;
        end
        arb_go = 1'b0;
        n_total++;
        if (exp_a1.size() != 0 || exp_a2.size() != 0)
            $display("FAIL arb_timeout got %0d/%0d pending want 0/0", exp_a1.size(), exp_a2.size());
        else n_pass++;
        n_total++;
        if (a2_tx != 0) $display("FAIL arb_pri_no_tx got %0d tx cycles want 0", a2_tx);
        else n_pass++;
        n_total++;
        if (a1_siwu != 0) $display("FAIL arb_siwu_disabled got %0d low cycles want 0", a1_siwu);
        else n_pass++;
        n_total++;
        if (bad_data != 0) $display("FAIL arb_data got %0d bad transfers want 0", bad_data);
        else n_pass++;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rx_single();
        test_rx_burst();
        test_rx_full();
        test_tx_flow();
        test_siwu();
        test_reset_mid_write();
        test_arbitration();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
